// File: rtl/i2c_target_responder.sv
// I2C target responder: oversamples SCL/SDA, answers one 7-bit address, delivers
// written bytes and serves read bytes from local logic. Never stretches SCL.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        o_sda,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_addr_hit,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   start_ev, stop_ev, rise_ev, fall_ev;

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic       sda_low, low_n;
  logic       rw, rw_n;
  logic       mack, mack_n;
  logic [7:0] rx_data, rxd_n;
  logic       rx_valid, rxv_n;
  logic       addr_hit, hit_n;
  logic       busy, busy_n;
  logic       tx_req, load_tx;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign rise_ev  = scl_s & ~scl_d;
  assign fall_ev  = ~scl_s & scl_d;

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    low_n   = sda_low;
    rw_n    = rw;
    mack_n  = mack;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    hit_n   = 1'b0;
    busy_n  = busy;
    load_tx = 1'b0;
    if (stop_ev) begin
      state_n = S_IDLE;
      low_n   = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = 4'd0;
    end else if (start_ev) begin
      state_n = S_ADDR;
      low_n   = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = 4'd0;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (rise_ev && bit_cnt != 4'd8) begin
            sh_n  = {shreg[6:0], sda_s};
            cnt_n = bit_cnt + 4'd1;
          end else if (fall_ev && bit_cnt == 4'd8) begin
            if (shreg[7:1] == TARGET_ADDR) begin
              low_n   = 1'b1;
              hit_n   = 1'b1;
              busy_n  = 1'b1;
              rw_n    = shreg[0];
              state_n = S_ADDR_ACK;
            end else begin
              state_n = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (fall_ev) begin
            if (!rw) begin
              low_n   = 1'b0;
              cnt_n   = 4'd0;
              state_n = S_WR_DATA;
            end else begin
              load_tx = 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (rise_ev && bit_cnt != 4'd8) begin
            sh_n  = {shreg[6:0], sda_s};
            cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rxd_n = sh_n;
              rxv_n = 1'b1;
            end
          end else if (fall_ev && bit_cnt == 4'd8) begin
            low_n   = 1'b1;
            state_n = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (fall_ev) begin
            low_n   = 1'b0;
            cnt_n   = 4'd0;
            state_n = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          // bit_cnt counts bits already presented; bit 7 went out at the load
          if (fall_ev) begin
            if (bit_cnt == 4'd8) begin
              low_n   = 1'b0;
              cnt_n   = 4'd0;
              state_n = S_RD_ACK;
            end else begin
              sh_n  = {shreg[6:0], 1'b0};
              low_n = ~shreg[6];
              cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (rise_ev) begin
            mack_n = sda_s;
          end else if (fall_ev) begin
            if (!mack) load_tx = 1'b1;
            else       state_n = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
    if (load_tx) begin
      sh_n    = i_tx_data;
      low_n   = ~i_tx_data[7];
      cnt_n   = 4'd1;
      state_n = S_RD_DATA;
    end
  end

  // Request is combinational so the byte is sampled in the very cycle it is asserted
  assign tx_req = load_tx & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      sda_low  <= 1'b0;
      rw       <= 1'b0;
      mack     <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      addr_hit <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], o_sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      state    <= state_n;
      bit_cnt  <= cnt_n;
      shreg    <= sh_n;
      sda_low  <= low_n;
      rw       <= rw_n;
      mack     <= mack_n;
      rx_data  <= rxd_n;
      rx_valid <= rxv_n;
      addr_hit <= hit_n;
      busy     <= busy_n;
    end
  end

  assign o_sda       = sda_low ? 1'b0 : 1'bz;
  assign o_tx_req    = tx_req;
  assign o_rx_data   = rx_data;
  assign o_rx_valid  = rx_valid;
  assign o_addr_hit  = addr_hit;
  assign o_busy      = busy;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-level I2C controller model drives the bus,
// and a byte-level expectation model checks strobes, data and SDA timing.
module tb_i2c_target_responder;
  localparam int SYNC = 2;
  localparam int HALF = SYNC + 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_scl;
  logic       ctrl_low;
  wire        sda;
  logic [7:0] i_tx_data;
  logic       o_tx_req, o_rx_valid, o_addr_hit, o_busy;
  logic [7:0] o_rx_data;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int n_hit = 0;
  int n_rxv = 0;
  int n_req = 0;
  logic       cond_win  = 1'b0;
  logic       sda_prev  = 1'b1;
  logic [2:0] strb_prev = 3'b000;
  logic [7:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  assign sda = ctrl_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  i2c_target_responder #(.TARGET_ADDR(7'h42), .SYNC_STAGES(SYNC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_scl(i_scl), .o_sda(sda),
    .i_tx_data(i_tx_data), .o_tx_req(o_tx_req), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .o_addr_hit(o_addr_hit), .o_busy(o_busy),
    .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe accounting, received-byte scoreboard and SDA-vs-SCL timing watch
  always @(negedge i_clk) begin
    logic [2:0] strb;
    strb = {o_addr_hit, o_rx_valid, o_tx_req};
    if (o_addr_hit) n_hit++;
    if (o_tx_req)   n_req++;
    if (strb != 3'b000) begin
      check("strobe_overlap", $countones(strb), 1);
      check("strobe_width", strb & strb_prev, 0);
    end
    if (o_rx_valid) begin
      n_rxv++;
      check("rx_expected_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rx_data", o_rx_data, exp_q.pop_front());
    end
    if (sda !== sda_prev) check("sda_edge_in_scl_low", i_scl & ~cond_win, 0);
    sda_prev  = sda;
    strb_prev = strb;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_start();
    if (!i_scl) begin
      ctrl_low = 1'b0;
      tick(HALF);
      i_scl = 1'b1;
      tick(HALF);
    end
    cond_win = 1'b1;
    ctrl_low = 1'b1;
    tick(HALF);
    i_scl = 1'b0;
    tick(1);
    cond_win = 1'b0;
  endtask

  task automatic send_stop();
    ctrl_low = 1'b1;
    tick(HALF);
    i_scl = 1'b1;
    tick(HALF);
    cond_win = 1'b1;
    ctrl_low = 1'b0;
    tick(HALF);
    cond_win = 1'b0;
    tick(HALF);
  endtask

  // Entered one cycle into SCL low; returns one cycle after the closing SCL fall
  task automatic send_bit(input logic b, output logic seen);
    ctrl_low = ~b;
    tick(HALF - 1);
    i_scl = 1'b1;
    tick(HALF - 1);
    @(negedge i_clk);
    seen = sda;
    @(posedge i_clk);
    #1;
    i_scl = 1'b0;
    tick(1);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], s);
      check({tag, "_bit"}, s, b[i]);
    end
    send_bit(1'b1, s);
    check({tag, "_ack"}, s, exp_ack);
  endtask

  task automatic read_byte(input logic [7:0] exp_b, input logic [7:0] next_tx,
                           input logic ack, input string tag);
    logic       s;
    logic [7:0] got;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      got = {got[6:0], s};
    end
    i_tx_data = next_tx;
    send_bit(~ack, s);
    check(tag, got, exp_b);
  endtask

  initial begin
    int h0, r0, q0;
    logic       s;
    logic       match, rw;
    logic [6:0] addr7;
    logic [7:0] d, cur, nxt;
    int         nb;

    i_rst = 1'b1;
    i_scl = 1'b1;
    ctrl_low = 1'b0;
    i_tx_data = 8'h00;
    tick(3);
    i_rst = 1'b0;
    tick(2);
    check("rst_busy", o_busy, 0);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_addr_hit", o_addr_hit, 0);
    check("rst_tx_req", o_tx_req, 0);
    check("rst_sda", sda, 1);

    // Write 0xA5 to our address
    h0 = n_hit; r0 = n_rxv;
    send_start();
    write_byte(8'h84, 1'b0, "t1_addr");
    check("t1_busy", o_busy, 1);
    check("t1_hit_once", n_hit - h0, 1);
    exp_q.push_back(8'hA5);
    write_byte(8'hA5, 1'b0, "t1_data");
    send_stop();
    check("t1_busy_after_stop", o_busy, 0);
    check("t1_rxv_once", n_rxv - r0, 1);
    check("t1_rx_data", o_rx_data, 8'hA5);

    // Read two bytes, ACK then NACK
    q0 = n_req;
    i_tx_data = 8'h3C;
    send_start();
    write_byte(8'h85, 1'b0, "t2_addr");
    read_byte(8'h3C, 8'hC3, 1'b1, "t2_byte0");
    read_byte(8'hC3, 8'h99, 1'b0, "t2_byte1");
    send_stop();
    check("t2_req_twice", n_req - q0, 2);
    check("t2_busy", o_busy, 0);

    // Foreign address: never driven, no strobes
    h0 = n_hit; r0 = n_rxv; q0 = n_req;
    send_start();
    write_byte(8'hA0, 1'b1, "t3_addr");
    check("t3_busy", o_busy, 0);
    write_byte(8'h55, 1'b1, "t3_data");
    send_stop();
    check("t3_no_hit", n_hit - h0, 0);
    check("t3_no_rxv", n_rxv - r0, 0);
    check("t3_no_req", n_req - q0, 0);

    // Write then repeated START into a read
    h0 = n_hit;
    send_start();
    write_byte(8'h84, 1'b0, "t4_waddr");
    exp_q.push_back(8'h10);
    write_byte(8'h10, 1'b0, "t4_wdata");
    i_tx_data = 8'h7E;
    send_start();
    check("t4_busy_cleared_by_sr", o_busy, 0);
    write_byte(8'h85, 1'b0, "t4_raddr");
    read_byte(8'h7E, 8'h00, 1'b0, "t4_rdata");
    send_stop();
    check("t4_rx_data", o_rx_data, 8'h10);
    check("t4_hits", n_hit - h0, 2);

    // STOP four bits into a write byte discards it
    r0 = n_rxv;
    send_start();
    write_byte(8'h84, 1'b0, "t5_addr");
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, s);
      check("t5_partial_bit", s, 1);
    end
    send_stop();
    check("t5_no_rxv", n_rxv - r0, 0);
    check("t5_rx_held", o_rx_data, 8'h10);
    check("t5_busy", o_busy, 0);

    // Reset while the target is driving a read bit low
    i_tx_data = 8'h00;
    send_start();
    write_byte(8'h85, 1'b0, "t5r_addr");
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, s);
      check("t5r_bit", s, 0);
    end
    tick(2);
    check("t5r_sda_driven", sda, 0);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check("t5r_sda_released", sda, 1);
    check("t5r_busy", o_busy, 0);
    check("t5r_rx_data", o_rx_data, 8'h00);
    check("t5r_strobes", {o_addr_hit, o_rx_valid, o_tx_req}, 0);
    send_stop();
    exp_q.push_back(8'h5A);
    send_start();
    write_byte(8'h84, 1'b0, "t5c_addr");
    write_byte(8'h5A, 1'b0, "t5c_data");
    send_stop();
    check("t5c_rx_data", o_rx_data, 8'h5A);

    // Randomized transactions against the byte-level model
    for (int k = 0; k < 8; k++) begin
      match = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      nb    = $urandom_range(1, 3);
      addr7 = 7'h42;
      if (!match) begin
        do addr7 = 7'($urandom_range(0, 127)); while (addr7 == 7'h42);
      end
      h0 = n_hit; q0 = n_req;
      if (match && rw) i_tx_data = 8'($urandom);
      cur = i_tx_data;
      send_start();
      write_byte({addr7, rw}, ~match, "rnd_addr");
      for (int j = 0; j < nb; j++) begin
        if (!match) begin
          write_byte(8'($urandom), 1'b1, "rnd_foreign");
        end else if (!rw) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          write_byte(d, 1'b0, "rnd_wr");
        end else begin
          nxt = 8'($urandom);
          read_byte(cur, nxt, (j != nb - 1), "rnd_rd");
          cur = nxt;
        end
      end
      send_stop();
      check("rnd_hits", n_hit - h0, {31'b0, match});
      check("rnd_reqs", n_req - q0, (match && rw) ? nb : 0);
      check("rnd_busy", o_busy, 0);
    end

    tick(4);
    check("rx_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
